// File: rtl/frankie_pkg.sv
// Shared constants for the Frankie program loader: word/address widths and FSM state encoding.
package frankie_pkg;

   localparam int FRANKIE_WORD_WIDTH = 16;
   localparam int FRANKIE_ADDR_WIDTH = 10;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;
   localparam logic [2:0] S_RUN  = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

endpackage

// File: rtl/frankie_loader_checksum.sv
// Modular image checksum: running sum of the length word and all data words, compared against
// the trailing checksum word. Only instantiated when FRANKIE_LOADER_CHECKSUM_EN is defined.
module frankie_loader_checksum
   import frankie_pkg::*;
#(
   parameter int WORD_WIDTH = FRANKIE_WORD_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_clear,
   input  logic                  i_add,
   input  logic [WORD_WIDTH-1:0] i_data,
   output logic                  o_match
);

   logic [WORD_WIDTH-1:0] r_sum;
   logic [WORD_WIDTH-1:0] w_base;
   logic [WORD_WIDTH-1:0] w_addend;

   // Clear and add in the same cycle seeds the sum with the length word.
   assign w_base   = i_clear ? '0 : r_sum;
   assign w_addend = i_add ? i_data : '0;
   assign o_match  = (i_data == r_sum);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sum <= '0;
      end else if (i_clear || i_add) begin
         r_sum <= w_base + w_addend;
      end
   end

endmodule

// File: rtl/frankie_program_loader.sv
// Streams a length-prefixed program image into Frankie's memory, then releases the CPU from reset.
// Optional trailing checksum word enabled by defining FRANKIE_LOADER_CHECKSUM_EN.
module frankie_program_loader
   import frankie_pkg::*;
#(
   parameter int WORD_WIDTH = FRANKIE_WORD_WIDTH,
   parameter int ADDR_WIDTH = FRANKIE_ADDR_WIDTH,
   parameter int RESET_HOLD = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_WIDTH-1:0] mem_wdata,
   output logic                  cpu_reset,
   output logic                  done,
   output logic                  error
);

   localparam logic [31:0] DEPTH  = 32'(1) << ADDR_WIDTH;
   localparam int          HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
`ifdef FRANKIE_LOADER_CHECKSUM_EN
   localparam logic [2:0]  S_POST = S_CHK;
`else
   localparam logic [2:0]  S_POST = S_HOLD;
`endif

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic                  w_ready;
   logic                  w_xfer;
   logic                  w_data_xfer;
   logic                  w_len_zero;
   logic                  w_len_big;
   logic                  w_last;
   logic                  w_hold_end;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_last;
   logic [HOLD_W-1:0]     r_hold;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WORD_WIDTH-1:0] r_wdata;
   logic                  r_cpu_reset;
   logic                  r_done;
   logic                  r_error;

   assign w_xfer      = in_valid && w_ready;
   assign w_data_xfer = w_xfer && (r_state == S_DATA);
   assign w_len_zero  = (in_data == '0);
   assign w_len_big   = 32'(in_data) > DEPTH;
   assign w_last      = (r_cnt == r_last);
   // The cycle carrying the final write pulse is not part of the hold window.
   assign w_hold_end  = !r_we && (r_hold == HOLD_W'(RESET_HOLD - 1));

`ifdef FRANKIE_LOADER_CHECKSUM_EN
   logic w_cs_match;

   frankie_loader_checksum #(.WORD_WIDTH(WORD_WIDTH)) u_checksum (
      .clock   (clock),
      .reset   (reset),
      .i_clear (r_state == S_LEN),
      .i_add   (w_xfer && ((r_state == S_LEN) || (r_state == S_DATA))),
      .i_data  (in_data),
      .o_match (w_cs_match)
   );
`endif

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: w_next = S_LEN;
         S_LEN: begin
            if (w_xfer) begin
               if (w_len_zero)     w_next = S_POST;
               else if (w_len_big) w_next = S_ERR;
               else                w_next = S_DATA;
            end
         end
         S_DATA: if (w_xfer && w_last) w_next = S_POST;
`ifdef FRANKIE_LOADER_CHECKSUM_EN
         S_CHK:  if (w_xfer) w_next = w_cs_match ? S_HOLD : S_ERR;
`endif
         S_HOLD: if (w_hold_end) w_next = S_RUN;
         default: w_next = r_state;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_LEN, S_DATA: w_ready = 1'b1;
`ifdef FRANKIE_LOADER_CHECKSUM_EN
         S_CHK:         w_ready = 1'b1;
`endif
         default:       w_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_last      <= '0;
         r_hold      <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_reset <= 1'b1;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_we <= w_data_xfer;
         if (w_xfer && (r_state == S_LEN)) begin
            r_cnt  <= '0;
            r_last <= ADDR_WIDTH'(in_data - 1'b1);
         end
         if (w_data_xfer) begin
            r_addr  <= r_cnt;
            r_wdata <= in_data;
            if (!w_last) r_cnt <= r_cnt + 1'b1;
         end
         if ((r_state == S_HOLD) && !r_we && !w_hold_end) r_hold <= r_hold + 1'b1;
         r_cpu_reset <= (w_next != S_RUN);
         r_done      <= (w_next == S_RUN);
         r_error     <= (w_next == S_ERR);
      end
   end

   assign in_ready  = w_ready;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign cpu_reset = r_cpu_reset;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_frankie_program_loader.sv
// Scoreboard bench for frankie_program_loader: expected writes are queued per image and popped
// by a monitor on every mem_we; load outcome and release timing are checked per image.
module tb_frankie_program_loader;

   localparam int WW    = 16;
   localparam int AW    = 10;
   localparam int RH    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [WW-1:0] in_data = '0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          error;

   frankie_program_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RESET_HOLD(RH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AW-1:0] a;
      logic [WW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   logic [WW-1:0] data_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            last_wr = -1;
   int            last_acc = -1;
   int            done_cyc = -1;
   logic          prev_done = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write strobe must match the next queued (addr, data).
   always @(negedge clock) begin
      wr_t e;
      if (in_valid && in_ready && !reset) last_acc = cyc;
      if (mem_we) begin
         last_wr = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(mem_addr), 32'(e.a));
            chk("write_data", 32'(mem_wdata), 32'(e.d));
         end
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_done = done;
   end

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_cpu_reset", 32'(cpu_reset), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      reset = 1'b0;
      last_wr = -1;
      last_acc = -1;
      done_cyc = -1;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [WW-1:0] w, input bit stall);
      int t;
      if (stall) begin
         repeat (1 + $urandom_range(0, 1)) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
         end
      end
      in_valid = 1'b1;
      in_data = w;
      t = 0;
      forever begin
         @(negedge clock);
         if (in_ready) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            break;
         end
         @(posedge clock);
         #1;
         t++;
         if (t > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: word %0h not accepted within 50 cycles", w);
            in_valid = 1'b0;
            break;
         end
      end
   endtask

   // Reference: an image of length n writes data_q[i] to address i when 1 <= n <= DEPTH;
   // an oversize length is rejected; the CPU is released RESET_HOLD idle cycles after the last
   // accepted word or write strobe, whichever is later.
   task automatic load(input logic [WW-1:0] n, input bit stall, input bit corrupt);
      logic [WW-1:0] sum;
      bit            exp_err;
      int            t;
      int            t0;
      $display("load: n=%0d stall=%0d corrupt=%0d", n, stall, corrupt);
      exp_err = (int'(n) > DEPTH);
      sum = n;
      if (!exp_err) begin
         for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back('{a: AW'(i), d: data_q[i]});
            sum = sum + data_q[i];
         end
      end
      send(n, stall);
      if (!exp_err) begin
         for (int i = 0; i < int'(n); i++) send(data_q[i], stall);
`ifdef FRANKIE_LOADER_CHECKSUM_EN
         send(corrupt ? (sum ^ 16'h0040) : sum, stall);
         exp_err = corrupt;
`endif
      end
      t = 0;
      while (!(done || error) && (t < RH + 30)) begin
         @(negedge clock);
         t++;
      end
      repeat (3) @(negedge clock);
      chk("pending_writes", 32'(exp_q.size()), 0);
      exp_q.delete();
      if (exp_err) begin
         chk("err_error", 32'(error), 1);
         chk("err_cpu_reset", 32'(cpu_reset), 1);
         chk("err_done", 32'(done), 0);
         chk("err_in_ready", 32'(in_ready), 0);
      end else begin
         t0 = (last_wr > last_acc) ? last_wr : last_acc;
         chk("run_done", 32'(done), 1);
         chk("run_cpu_reset", 32'(cpu_reset), 0);
         chk("run_error", 32'(error), 0);
         chk("run_in_ready", 32'(in_ready), 0);
         chk("release_cycle", 32'(done_cyc), 32'(t0 + RH + 1));
      end
      @(posedge clock);
      #1;
   endtask

   task automatic fill_random(input int n);
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(WW'($urandom));
   endtask

   initial begin
      int n;
      // basic image, back-to-back and with a stalling source
      data_q = '{16'h7002, 16'h7305, 16'h0012};
      do_reset();
      load(16'd3, 1'b0, 1'b0);
      do_reset();
      load(16'd3, 1'b1, 1'b0);

      // empty and oversize images
      do_reset();
      load(16'd0, 1'b0, 1'b0);
      do_reset();
      load(16'd1025, 1'b0, 1'b0);
      do_reset();
      load(WW'($urandom_range(1026, 65535)), 1'b0, 1'b0);

      // reset after two of five words: both accepted words written, nothing after
      do_reset();
      exp_q.push_back('{a: AW'(0), d: 16'h1111});
      exp_q.push_back('{a: AW'(1), d: 16'h2222});
      send(16'd5, 1'b0);
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b0);
      do_reset();
      chk("midload_writes_left", 32'(exp_q.size()), 0);
      data_q = '{16'hABCD};
      load(16'd1, 1'b0, 1'b0);

      // full depth
      fill_random(DEPTH);
      do_reset();
      load(16'(DEPTH), 1'b0, 1'b0);

`ifdef FRANKIE_LOADER_CHECKSUM_EN
      data_q = '{16'h0001, 16'h0002};
      do_reset();
      load(16'd2, 1'b0, 1'b0);
      do_reset();
      load(16'd2, 1'b0, 1'b1);
`endif

      // randomized images
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(1, 24);
         fill_random(n);
         do_reset();
`ifdef FRANKIE_LOADER_CHECKSUM_EN
         load(WW'(n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         load(WW'(n), 1'($urandom_range(0, 1)), 1'b0);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
